// File: rtl/dof_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dof_pkg : opcode map, control encodings and control-word type      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dof_pkg;

    localparam logic [6:0] OP_NOP = 7'b0000000;
    localparam logic [6:0] OP_ADD = 7'b0000010;
    localparam logic [6:0] OP_SUB = 7'b0000101;
    localparam logic [6:0] OP_SLT = 7'b1100101;
    localparam logic [6:0] OP_AND = 7'b0001000;
    localparam logic [6:0] OP_OR  = 7'b0001010;
    localparam logic [6:0] OP_XOR = 7'b0001100;
    localparam logic [6:0] OP_ST  = 7'b0000001;
    localparam logic [6:0] OP_LD  = 7'b0100001;
    localparam logic [6:0] OP_ADI = 7'b0100010;
    localparam logic [6:0] OP_SBI = 7'b0100101;
    localparam logic [6:0] OP_NOT = 7'b0101110;
    localparam logic [6:0] OP_ANI = 7'b0101000;
    localparam logic [6:0] OP_ORI = 7'b0101010;
    localparam logic [6:0] OP_XRI = 7'b0101100;
    localparam logic [6:0] OP_AIU = 7'b1100010;
    localparam logic [6:0] OP_SIU = 7'b1000101;
    localparam logic [6:0] OP_MOV = 7'b1000000;
    localparam logic [6:0] OP_LSL = 7'b0110010;
    localparam logic [6:0] OP_LSR = 7'b0110001;
    localparam logic [6:0] OP_JMR = 7'b1100001;
    localparam logic [6:0] OP_BZ  = 7'b0100000;
    localparam logic [6:0] OP_BNZ = 7'b1100000;
    localparam logic [6:0] OP_JMP = 7'b1000100;
    localparam logic [6:0] OP_JML = 7'b0000111;

    localparam logic [4:0] FS_A   = 5'b00000;
    localparam logic [4:0] FS_ADD = 5'b00010;
    localparam logic [4:0] FS_SUB = 5'b00101;
    localparam logic [4:0] FS_AND = 5'b01000;
    localparam logic [4:0] FS_OR  = 5'b01010;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_NOT = 5'b01110;
    localparam logic [4:0] FS_SHR = 5'b10100;
    localparam logic [4:0] FS_SHL = 5'b11000;

    localparam logic [1:0] MD_FU  = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_SLT = 2'b10;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_ZERO = 2'b01;
    localparam logic [1:0] BS_JR   = 2'b10;
    localparam logic [1:0] BS_JMP  = 2'b11;

    typedef struct packed {
        logic       rw;
        logic [1:0] md;
        logic [1:0] bs;
        logic       ps;
        logic       mw;
        logic [4:0] fs;
        logic       mb;
        logic       ma;
        logic       cs;
    } ctrl_t;

    function automatic ctrl_t cw(input logic rw, input logic [1:0] md,
                                 input logic [1:0] bs, input logic ps,
                                 input logic mw, input logic [4:0] fs,
                                 input logic mb, input logic ma,
                                 input logic cs);
        ctrl_t c;
        c.rw = rw; c.md = md; c.bs = bs; c.ps = ps; c.mw = mw;
        c.fs = fs; c.mb = mb; c.ma = ma; c.cs = cs;
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dof_instr_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dof_instr_decoder : opcode -> control word, purely combinational   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dof_instr_decoder
    import dof_pkg::*;
(
    input  logic [6:0] i_opcode,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            //               RW    MD      BS       PS    MW    FS      MB    MA    CS
            OP_ADD: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_ADD, 1'b0, 1'b0, 1'b0);
            OP_SUB: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_SUB, 1'b0, 1'b0, 1'b0);
            OP_SLT: o_ctrl = cw(1'b1, MD_SLT, BS_NONE, 1'b0, 1'b0, FS_SUB, 1'b0, 1'b0, 1'b0);
            OP_AND: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_AND, 1'b0, 1'b0, 1'b0);
            OP_OR:  o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_OR,  1'b0, 1'b0, 1'b0);
            OP_XOR: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_XOR, 1'b0, 1'b0, 1'b0);
            OP_ST:  o_ctrl = cw(1'b0, MD_FU,  BS_NONE, 1'b0, 1'b1, FS_A,   1'b0, 1'b0, 1'b0);
            OP_LD:  o_ctrl = cw(1'b1, MD_MEM, BS_NONE, 1'b0, 1'b0, FS_A,   1'b0, 1'b0, 1'b0);
            OP_ADI: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b1);
            OP_SBI: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b1);
            OP_NOT: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_NOT, 1'b0, 1'b0, 1'b0);
            OP_ANI: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_AND, 1'b1, 1'b0, 1'b0);
            OP_ORI: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_OR,  1'b1, 1'b0, 1'b0);
            OP_XRI: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_XOR, 1'b1, 1'b0, 1'b0);
            OP_AIU: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
            OP_SIU: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_SUB, 1'b1, 1'b0, 1'b0);
            OP_MOV: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_A,   1'b0, 1'b0, 1'b0);
            OP_LSL: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_SHL, 1'b1, 1'b0, 1'b0);
            OP_LSR: o_ctrl = cw(1'b1, MD_FU,  BS_NONE, 1'b0, 1'b0, FS_SHR, 1'b1, 1'b0, 1'b0);
            OP_JMR: o_ctrl = cw(1'b0, MD_FU,  BS_JR,   1'b0, 1'b0, FS_A,   1'b0, 1'b0, 1'b0);
            OP_BZ:  o_ctrl = cw(1'b0, MD_FU,  BS_ZERO, 1'b0, 1'b0, FS_A,   1'b1, 1'b0, 1'b1);
            OP_BNZ: o_ctrl = cw(1'b0, MD_FU,  BS_ZERO, 1'b1, 1'b0, FS_A,   1'b1, 1'b0, 1'b1);
            OP_JMP: o_ctrl = cw(1'b0, MD_FU,  BS_JMP,  1'b0, 1'b0, FS_A,   1'b1, 1'b0, 1'b1);
            // Jump-and-link routes PC-1 through the A path so the FU passes it to R[DR]
            OP_JML: o_ctrl = cw(1'b1, MD_FU,  BS_JMP,  1'b0, 1'b0, FS_A,   1'b1, 1'b1, 1'b1);
            default: o_ctrl = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dof.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dof : decode/operand-fetch stage, outputs form the DOF/EX register |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dof
    import dof_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] PCM1,
    input  logic [31:0] IR,
    input  logic [31:0] ADATA,
    input  logic [31:0] BDATA,
    output logic [4:0]  AA,
    output logic [4:0]  BA,
    output logic        RW,
    output logic [4:0]  DA,
    output logic [1:0]  MD,
    output logic [1:0]  BS,
    output logic        PS,
    output logic        MW,
    output logic [4:0]  FS,
    output logic [31:0] ABUS,
    output logic [31:0] BBUS
);

    ctrl_t       w_ctrl;
    logic [31:0] w_const;
    logic [31:0] w_a;
    logic [31:0] w_b;

    logic        r_rw;
    logic [4:0]  r_da;
    logic [1:0]  r_md;
    logic [1:0]  r_bs;
    logic        r_ps;
    logic        r_mw;
    logic [4:0]  r_fs;
    logic [31:0] r_abus;
    logic [31:0] r_bbus;

    dof_instr_decoder u_decoder (
        .i_opcode (IR[31:25]),
        .o_ctrl   (w_ctrl)
    );

    assign AA = IR[19:15];
    assign BA = IR[14:10];

    assign w_const = w_ctrl.cs ? {{17{IR[14]}}, IR[14:0]} : {17'b0, IR[14:0]};
    assign w_a     = w_ctrl.ma ? {16'b0, PCM1} : ADATA;
    assign w_b     = w_ctrl.mb ? w_const : BDATA;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rw   <= 1'b0;
            r_da   <= 5'd0;
            r_md   <= 2'b00;
            r_bs   <= 2'b00;
            r_ps   <= 1'b0;
            r_mw   <= 1'b0;
            r_fs   <= 5'd0;
            r_abus <= 32'd0;
            r_bbus <= 32'd0;
        end else begin
            r_rw   <= w_ctrl.rw;
            r_da   <= IR[24:20];
            r_md   <= w_ctrl.md;
            r_bs   <= w_ctrl.bs;
            r_ps   <= w_ctrl.ps;
            r_mw   <= w_ctrl.mw;
            r_fs   <= w_ctrl.fs;
            r_abus <= w_a;
            r_bbus <= w_b;
        end
    end

    assign RW   = r_rw;
    assign DA   = r_da;
    assign MD   = r_md;
    assign BS   = r_bs;
    assign PS   = r_ps;
    assign MW   = r_mw;
    assign FS   = r_fs;
    assign ABUS = r_abus;
    assign BBUS = r_bbus;

endmodule
`default_nettype wire

// File: tb/tb_dof.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dof : self-checking bench for the DOF stage (queue scoreboard)  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dof;

    typedef struct packed {
        logic        rw;
        logic [4:0]  da;
        logic [1:0]  md;
        logic [1:0]  bs;
        logic        ps;
        logic        mw;
        logic [4:0]  fs;
        logic [31:0] abus;
        logic [31:0] bbus;
    } obs_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] PCM1;
    logic [31:0] IR;
    logic [31:0] ADATA;
    logic [31:0] BDATA;
    logic [4:0]  AA;
    logic [4:0]  BA;
    logic        RW;
    logic [4:0]  DA;
    logic [1:0]  MD;
    logic [1:0]  BS;
    logic        PS;
    logic        MW;
    logic [4:0]  FS;
    logic [31:0] ABUS;
    logic [31:0] BBUS;

    int   n_checks;
    int   n_pass;
    obs_t sb_q[$];
    obs_t exp_v;
    obs_t act_v;

    dof dut (
        .clk   (clk),
        .rst_n (rst_n),
        .PCM1  (PCM1),
        .IR    (IR),
        .ADATA (ADATA),
        .BDATA (BDATA),
        .AA    (AA),
        .BA    (BA),
        .RW    (RW),
        .DA    (DA),
        .MD    (MD),
        .BS    (BS),
        .PS    (PS),
        .MW    (MW),
        .FS    (FS),
        .ABUS  (ABUS),
        .BBUS  (BBUS)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign act_v = '{RW, DA, MD, BS, PS, MW, FS, ABUS, BBUS};

    function automatic obs_t mk(input logic rw, input logic [4:0] da,
                                input logic [1:0] md, input logic [1:0] bs,
                                input logic ps, input logic mw,
                                input logic [4:0] fs, input logic [31:0] abus,
                                input logic [31:0] bbus);
        obs_t o;
        o.rw = rw; o.da = da; o.md = md; o.bs = bs; o.ps = ps; o.mw = mw;
        o.fs = fs; o.abus = abus; o.bbus = bbus;
        return o;
    endfunction

    // Inputs change on the falling edge, away from the sampling edge.
    task automatic drive(input logic [6:0] op, input logic [4:0] dr,
                         input logic [4:0] sa, input logic [14:0] im,
                         input logic [15:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input obs_t e);
        @(negedge clk);
        IR    = {op, dr, sa, im};
        PCM1  = pc;
        ADATA = a;
        BDATA = b;
        sb_q.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        IR = {7'b0000010, 5'd5, 5'd3, 15'h0800};
        PCM1 = 16'd0; ADATA = 32'd100; BDATA = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (act_v !== '0)
            $display("FAIL reset_state: got %h want 0", act_v);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add;
        drive(7'b0000010, 5'd5, 5'd3, 15'h0800, 16'd0, 32'd100, 32'd0,
              mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00010, 32'd100, 32'd0));
        #1;
        n_checks++;
        if (AA !== 5'd3) $display("FAIL add_AA: got %0d want 3", AA);
        else n_pass++;
        n_checks++;
        if (BA !== 5'd2) $display("FAIL add_BA: got %0d want 2", BA);
        else n_pass++;
        @(posedge clk);
        #1;
        exp_v = sb_q.pop_front();
        n_checks++;
        if (act_v !== exp_v) $display("FAIL add: got %h want %h", act_v, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        // Outputs still hold the ADD result here; reset must clear without an edge.
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (act_v !== '0)
            $display("FAIL reset_midrun: got %h want 0", act_v);
        else
            n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_one(input string name, input logic [6:0] op,
                           input logic [14:0] im, input logic [15:0] pc,
                           input logic [31:0] a, input logic [31:0] b,
                           input obs_t e);
        drive(op, 5'd5, 5'd3, im, pc, a, b, e);
        @(posedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            exp_v = sb_q.pop_front();
            if (act_v !== exp_v) $display("FAIL %s: got %h want %h", name, act_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_immediate;
        run_one("adi", 7'b0100010, 15'h0800, 16'd0, 32'd100, 32'd10,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00010, 32'd100, 32'd2048));
        run_one("jml", 7'b0000111, 15'h0800, 16'd4, 32'd100, 32'd10,
                mk(1'b1, 5'd5, 2'b00, 2'b11, 1'b0, 1'b0, 5'b00000, 32'd4, 32'd2048));
    endtask

    task automatic test_extension;
        run_one("sbi_sext", 7'b0100101, 15'h7FFF, 16'd9, 32'd7, 32'd1,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00101, 32'd7, 32'hFFFFFFFF));
        run_one("ani_zext", 7'b0101000, 15'h7FFF, 16'd9, 32'd7, 32'd1,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01000, 32'd7, 32'h00007FFF));
    endtask

    task automatic test_branch_store;
        run_one("bnz", 7'b1100000, 15'h0010, 16'd3, 32'd11, 32'd22,
                mk(1'b0, 5'd5, 2'b00, 2'b01, 1'b1, 1'b0, 5'b00000, 32'd11, 32'd16));
        run_one("st", 7'b0000001, 15'h0C00, 16'd3, 32'd11, 32'd22,
                mk(1'b0, 5'd5, 2'b00, 2'b00, 1'b0, 1'b1, 5'b00000, 32'd11, 32'd22));
        run_one("unknown", 7'b1111111, 15'h7FFF, 16'd3, 32'd11, 32'd22,
                mk(1'b0, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 32'd11, 32'd22));
    endtask

    task automatic test_back_to_back;
        run_one("ld",  7'b0100001, 15'h0001, 16'd1, 32'hA5A5_0000, 32'h0000_5A5A,
                mk(1'b1, 5'd5, 2'b01, 2'b00, 1'b0, 1'b0, 5'b00000, 32'hA5A5_0000, 32'h0000_5A5A));
        run_one("slt", 7'b1100101, 15'h0001, 16'd1, 32'd3, 32'd4,
                mk(1'b1, 5'd5, 2'b10, 2'b00, 1'b0, 1'b0, 5'b00101, 32'd3, 32'd4));
        run_one("jmr", 7'b1100001, 15'h0001, 16'd1, 32'd77, 32'd4,
                mk(1'b0, 5'd5, 2'b00, 2'b10, 1'b0, 1'b0, 5'b00000, 32'd77, 32'd4));
        run_one("lsl", 7'b0110010, 15'h4003, 16'd1, 32'd8, 32'd4,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b11000, 32'd8, 32'h0000_4003));
        run_one("lsr", 7'b0110001, 15'h0002, 16'd1, 32'd8, 32'd4,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b10100, 32'd8, 32'd2));
        run_one("not", 7'b0101110, 15'h0002, 16'd1, 32'd8, 32'd4,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b01110, 32'd8, 32'd4));
        run_one("jmp", 7'b1000100, 15'h4001, 16'd1, 32'd8, 32'd4,
                mk(1'b0, 5'd5, 2'b00, 2'b11, 1'b0, 1'b0, 5'b00000, 32'd8, 32'hFFFF_C001));
        run_one("bz",  7'b0100000, 15'h0020, 16'd1, 32'd8, 32'd4,
                mk(1'b0, 5'd5, 2'b00, 2'b01, 1'b0, 1'b0, 5'b00000, 32'd8, 32'd32));
        run_one("aiu", 7'b1100010, 15'h4000, 16'd1, 32'd8, 32'd4,
                mk(1'b1, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00010, 32'd8, 32'h0000_4000));
        run_one("nop", 7'b0000000, 15'h4000, 16'd1, 32'd8, 32'd4,
                mk(1'b0, 5'd5, 2'b00, 2'b00, 1'b0, 1'b0, 5'b00000, 32'd8, 32'd4));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_add();
        test_reset_midrun();
        test_immediate();
        test_extension();
        test_branch_store();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dof.md
# dof

Decode-and-operand-fetch (DOF) stage of the five-stage pipelined RISC datapath, between the IF/DOF pipeline register and the execute stage. It decodes the 32-bit instruction into control words, drives register-file read addresses, and selects the A and B operands from register data, PC-1 or a generated immediate constant. Its outputs form the DOF/EX pipeline register.

## Interface
- No parameters; opcode encodings come from the shared package.
- clk  in  1  stage clock, rising edge active
- rst_n  in  1  asynchronous, active-low reset
- PCM1  in  16  PC-1 of the instruction in DOF
- IR  in  32  instruction: opcode [31:25], DR [24:20], SA [19:15], SB [14:10], IM [14:0]
- ADATA  in  32  register-file read data for AA
- BDATA  in  32  register-file read data for BA
- AA  out  5  register-file A address, combinational = IR[19:15]
- BA  out  5  register-file B address, combinational = IR[14:10]
- RW  out  1  register write enable (registered)
- DA  out  5  destination register = IR[24:20] (registered)
- MD  out  2  write-back select: 00 function unit, 01 memory, 10 status/SLT (registered)
- BS  out  2  branch select: 00 none, 01 conditional on zero, 10 jump register, 11 jump/branch unconditional (registered)
- PS  out  1  zero-branch polarity: 0 BZ, 1 BNZ (registered)
- MW  out  1  memory write (registered)
- FS  out  5  function-unit select (registered)
- ABUS  out  32  A operand (registered)
- BBUS  out  32  B operand (registered)

## Operation
- Operand A: MA=1 gives {16'b0, PCM1}; otherwise ADATA.
- Operand B: MB=1 gives the constant; otherwise BDATA.
- Constant: CS=1 sign-extends IM[14:0] (bit 14 replicated), CS=0 zero-extends it.
- FS codes: 00000 A, 00010 A+B, 00101 A-B, 01000 AND, 01010 OR, 01100 XOR, 01110 NOT A, 10100 shift right, 11000 shift left.
- Decode, listed as RW MD BS PS MW FS MB MA CS. Any field not listed is 0.
- NOP 0000000: all zero.
- ADD 0000010: 1 00 00 0 0 00010 0 0 0
- SUB 0000101 and SLT 1100101: FS 00101. SLT uses MD=10. Both have RW=1.
- AND 0001000, OR 0001010, XOR 0001100: RW=1, FS 01000 / 01010 / 01100 respectively.
- ST 0000001: MW=1, RW=0, FS 00000.
- LD 0100001: RW=1, MD=01, FS 00000.
- ADI 0100010: RW=1, FS 00010, MB=1, CS=1.
- SBI 0100101: RW=1, FS 00101, MB=1, CS=1.
- NOT 0101110: RW=1, FS 01110.
- ANI 0101000, ORI 0101010, XRI 0101100: RW=1, MB=1, CS=0, FS 01000 / 01010 / 01100 respectively.
- AIU 1100010: RW=1, MB=1, CS=0, FS 00010.
- SIU 1000101: RW=1, MB=1, CS=0, FS 00101.
- MOV 1000000: RW=1, FS 00000.
- LSL 0110010: RW=1, MB=1, CS=0, FS 11000.
- LSR 0110001: RW=1, MB=1, CS=0, FS 10100.
- JMR 1100001: BS=10, RW=0.
- BZ 0100000: BS=01, PS=0, MB=1, CS=1.
- BNZ 1100000: BS=01, PS=1, MB=1, CS=1.
- JMP 1000100: BS=11, MB=1, CS=1.
- JML 0000111: RW=1, MD=00, BS=11, MA=1, MB=1, CS=1, FS 00000. R[DR] receives PC-1.
- Unlisted opcodes decode exactly as NOP.
- MB, MA and CS are internal signals only.

## Timing
- AA and BA are combinational from IR with zero cycle delay, so register-file reads complete in the same cycle.
- All other outputs update on the rising clk edge: 1-cycle latency from IR/PCM1/ADATA/BDATA.
- rst_n low, at any time: registered outputs clear to 0 immediately. This is the NOP word: RW=0, MW=0, BS=00, PS=0, MD=00, FS=00000, DA=0, ABUS=0, BBUS=0.
- First edge after rst_n rises loads the decoded instruction.
- No stall or flush input. Hazard handling lives outside this block.

## Structure
- Shared package holds:
  - the 7-bit opcode constants;
  - the FS, MD and BS encodings;
  - a control-word struct {RW, MD, BS, PS, MW, FS, MB, MA, CS}.
- One natural sub-module: instr_decoder, combinational, mapping opcode to control word.
- Constant generator, both muxes and the pipeline register sit in the top-level dof.

## Test plan
- Reset: assert rst_n=0 mid-run with ADD in IR -> all registered outputs 0 immediately, with no clock edge.
- ADD with DR=5, SA=3, SB=2, ADATA=100, BDATA=0:
  - AA=3 and BA=2 combinationally.
  - After the edge: RW=1, DA=5, MD=00, BS=00, FS=00010, ABUS=100, BBUS=0.
- ADI with the same fields (IM=15'h0800), ADATA=100, BDATA=10 -> after the edge: BBUS=32'd2048, ABUS=100, FS=00010, RW=1.
- JML with the same fields and PCM1=4 -> after the edge: ABUS=4, BBUS=2048, BS=11, RW=1, DA=5, FS=00000.
- Sign/zero extension with IM=15'h7FFF:
  - SBI -> BBUS=32'hFFFFFFFF.
  - ANI -> BBUS=32'h00007FFF.
- Branch and store decode:
  - BNZ -> BS=01, PS=1, RW=0.
  - ST -> MW=1, RW=0.
  - Unknown opcode 1111111 -> all control outputs 0.
